vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen_if.sv | 31 +++
 rtl/vga_timing_gen.sv | 129 ++++++++++++
 tb/tb_vga_timing_gen.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Pixel-coordinate / color / VGA connector bundle for vga_timing_gen.
// master = timing generator, slave = the pixel generator and DAC side.
interface vga_timing_gen_if;
  logic [10:0] o_x;
  logic [10:0] o_y;
  logic [9:0]  i_red;
  logic [9:0]  i_green;
  logic [9:0]  i_blue;
  logic [7:0]  o_vga_r;
  logic [7:0]  o_vga_g;
  logic [7:0]  o_vga_b;
  logic        o_vga_hs;
  logic        o_vga_vs;
  logic        o_vga_blank_n;
  logic        o_vga_sync_n;
  logic        o_frame_start;

  modport master (
    output o_x, o_y,
    input  i_red, i_green, i_blue,
    output o_vga_r, o_vga_g, o_vga_b,
    output o_vga_hs, o_vga_vs, o_vga_blank_n, o_vga_sync_n, o_frame_start
  );

  modport slave (
    input  o_x, o_y,
    output i_red, i_green, i_blue,
    input  o_vga_r, o_vga_g, o_vga_b,
    input  o_vga_hs, o_vga_vs, o_vga_blank_n, o_vga_sync_n, o_frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA timing generator: free-running h/v counters plus one registered output stage
// for color, sync and blank. Define VGA_TESTBAR_EN for 8 vertical color bars.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  vga_timing_gen_if.master   bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT      = 11'(V_ACTIVE);
  localparam logic [10:0] HS_FIRST   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_LAST    = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] VS_FIRST   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_LAST    = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [10:0] r_h_cnt;
  logic [10:0] r_v_cnt;
  logic [7:0]  r_vga_r;
  logic [7:0]  r_vga_g;
  logic [7:0]  r_vga_b;
  logic        r_vga_hs;
  logic        r_vga_vs;
  logic        r_vga_blank_n;
  logic        r_frame_start;

  logic        w_h_wrap;
  logic        w_v_wrap;
  logic        w_active;
  logic        w_hs_act;
  logic        w_vs_act;
  logic [7:0]  w_r;
  logic [7:0]  w_g;
  logic [7:0]  w_b;
  logic        w_unused_bits;

  assign w_h_wrap = (r_h_cnt == H_LAST);
  assign w_v_wrap = (r_v_cnt == V_LAST);
  assign w_active = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
  assign w_hs_act = (r_h_cnt >= HS_FIRST) && (r_h_cnt <= HS_LAST);
  assign w_vs_act = (r_v_cnt >= VS_FIRST) && (r_v_cnt <= VS_LAST);

  // v_cnt advances (and wraps) only on the h wrap, so (H_ACTIVE, V_ACTIVE) occurs once per frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else begin
      // NOTE: non-blocking so every register in this clock domain sees the pre-edge counter values.
      r_h_cnt <= w_h_wrap ? '0 : r_h_cnt + 11'd1;
      if (w_h_wrap) begin
        r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 11'd1;
      end
    end
  end

`ifdef VGA_TESTBAR_EN
  logic [10:0] w_bar_idx;
  assign w_bar_idx     = 11'(r_h_cnt / 11'(H_ACTIVE / 8));
  assign w_unused_bits = ^{bus.i_red, bus.i_green, bus.i_blue, w_bar_idx[10:3]};
`else
  // Only the upper 8 color bits reach the DAC; truncation, not rounding.
  assign w_unused_bits = ^{bus.i_red[1:0], bus.i_green[1:0], bus.i_blue[1:0]};
`endif

  always_comb begin
    // NOTE: defaults first so blanked pixels are zero and no path can infer a latch.
    w_r = '0;
    w_g = '0;
    w_b = '0;
    if (w_active) begin
`ifdef VGA_TESTBAR_EN
      w_r = {8{w_bar_idx[2]}};
      w_g = {8{w_bar_idx[1]}};
      w_b = {8{w_bar_idx[0]}};
`else
      w_r = bus.i_red[9:2];
      w_g = bus.i_green[9:2];
      w_b = bus.i_blue[9:2];
`endif
    end
  end

  // Single output stage: color, sync, blank and frame marker share the same latency.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vga_r       <= '0;
      r_vga_g       <= '0;
      r_vga_b       <= '0;
      r_vga_hs      <= 1'b1;
      r_vga_vs      <= 1'b1;
      r_vga_blank_n <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_vga_r       <= w_r;
      r_vga_g       <= w_g;
      r_vga_b       <= w_b;
      r_vga_hs      <= ~w_hs_act;
      r_vga_vs      <= ~w_vs_act;
      r_vga_blank_n <= w_active;
      r_frame_start <= (r_h_cnt == '0) && (r_v_cnt == '0);
    end
  end

  assign bus.o_x           = r_h_cnt;
  assign bus.o_y           = r_v_cnt;
  assign bus.o_vga_r       = r_vga_r;
  assign bus.o_vga_g       = r_vga_g;
  assign bus.o_vga_b       = r_vga_b;
  assign bus.o_vga_hs      = r_vga_hs;
  assign bus.o_vga_vs      = r_vga_vs;
  assign bus.o_vga_blank_n = r_vga_blank_n;
  assign bus.o_vga_sync_n  = 1'b0;
  assign bus.o_frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a reduced 48x19 raster so whole frames run quickly.
// Table vectors for per-pixel outputs, monitor over two frames for timing totals.
module tb_vga_timing_gen;

  localparam int H_ACTIVE = 32;
  localparam int H_FP     = 4;
  localparam int H_SYNC   = 8;
  localparam int H_BP     = 4;
  localparam int V_ACTIVE = 12;
  localparam int V_FP     = 2;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 3;
  localparam int H_TOTAL  = 48;
  localparam int V_TOTAL  = 19;
  localparam int FRAME    = H_TOTAL * V_TOTAL;  // 912 clocks

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #20 clk = ~clk;

  vga_timing_gen_if vif ();

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (vif.master)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_rgb(input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
    vif.i_red   = r;
    vif.i_green = g;
    vif.i_blue  = b;
  endtask

`ifdef VGA_TESTBAR_EN
  function automatic logic [23:0] bar(input int x);
    int idx;
    idx = x / (H_ACTIVE / 8);
    return {{8{idx[2]}}, {8{idx[1]}}, {8{idx[0]}}};
  endfunction
`endif

  // Reference raster position: (m_h, m_v) is what o_x/o_y should show,
  // (m_ph, m_pv) is the pixel the registered VGA outputs currently carry.
  int m_h, m_v, m_ph, m_pv;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_h <= 0; m_v <= 0; m_ph <= 0; m_pv <= 0;
    end else begin
      m_ph <= m_h;
      m_pv <= m_v;
      if (m_h == H_TOTAL - 1) begin
        m_h <= 0;
        m_v <= (m_v == V_TOTAL - 1) ? 0 : m_v + 1;
      end else begin
        m_h <= m_h + 1;
      end
    end
  end

  task automatic goto(input int x, input int y);
    int n = 0;
    while (!(m_h == x && m_v == y) && n < 2 * FRAME) begin
      step();
      n++;
    end
    check($sformatf("goto_%0d_%0d_reached", x, y), {31'd0, (m_h == x && m_v == y)}, 32'd1);
  endtask

  // Two-frame monitor: exactly 2*FRAME samples, so totals are independent of start phase.
  logic mon_en = 1'b0;
  int mon_cnt = 0, hs_low = 0, vs_low = 0, act_cnt = 0, corner_cnt = 0;
  int coord_err = 0, blank_err = 0, color_err = 0, sync_err = 0, blank_pos_err = 0;
  int hs_fall_err = 0, vs_fall_err = 0, fs_cnt = 0, fs_pos_err = 0, fs_period = 0, last_fs = 0;
  logic prev_hs = 1'b1, prev_vs = 1'b1;
  logic [23:0] exp_active;

  always_comb begin
`ifdef VGA_TESTBAR_EN
    exp_active = bar(m_ph);
`else
    exp_active = 24'hFFFFFF;
`endif
  end

  always @(negedge clk) begin
    if (mon_en && mon_cnt < 2 * FRAME) begin
      mon_cnt <= mon_cnt + 1;
      if (!vif.o_vga_hs) hs_low <= hs_low + 1;
      if (!vif.o_vga_vs) vs_low <= vs_low + 1;
      if (vif.o_vga_blank_n) act_cnt <= act_cnt + 1;
      if (int'(vif.o_x) != m_h || int'(vif.o_y) != m_v) coord_err <= coord_err + 1;
      if (int'(vif.o_x) == H_ACTIVE && int'(vif.o_y) == V_ACTIVE) corner_cnt <= corner_cnt + 1;
      if (!vif.o_vga_blank_n && {vif.o_vga_r, vif.o_vga_g, vif.o_vga_b} != 24'h0)
        blank_err <= blank_err + 1;
      if (vif.o_vga_blank_n && {vif.o_vga_r, vif.o_vga_g, vif.o_vga_b} != exp_active)
        color_err <= color_err + 1;
      if (vif.o_vga_sync_n !== 1'b0) sync_err <= sync_err + 1;
      if (vif.o_vga_blank_n != (m_ph < H_ACTIVE && m_pv < V_ACTIVE))
        blank_pos_err <= blank_pos_err + 1;
      if (mon_cnt > 0 && prev_hs && !vif.o_vga_hs && m_ph != H_ACTIVE + H_FP)
        hs_fall_err <= hs_fall_err + 1;
      if (mon_cnt > 0 && prev_vs && !vif.o_vga_vs && !(m_ph == 0 && m_pv == V_ACTIVE + V_FP))
        vs_fall_err <= vs_fall_err + 1;
      prev_hs <= vif.o_vga_hs;
      prev_vs <= vif.o_vga_vs;
      if (vif.o_frame_start) begin
        fs_cnt  <= fs_cnt + 1;
        last_fs <= mon_cnt;
        if (fs_cnt > 0) fs_period <= mon_cnt - last_fs;
        if (m_ph != 0 || m_pv != 0) fs_pos_err <= fs_pos_err + 1;
      end
    end
  end

  typedef struct {
    int          x;
    int          y;
    logic [9:0]  r, g, b;
    logic [7:0]  er, eg, eb;
    logic        ehs, evs, ebl, efs;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] er, eg, eb;
    int n;

    //               x   y   red      green    blue     r      g      b      hs vs bl fs
    vecs[0]  = '{ 5,  0, 10'h000, 10'h203, 10'h000, 8'h00, 8'h80, 8'h00, 1, 1, 1, 0};
    vecs[1]  = '{31,  0, 10'h3FF, 10'h3FF, 10'h3FF, 8'hFF, 8'hFF, 8'hFF, 1, 1, 1, 0};
    vecs[2]  = '{32,  0, 10'h3FF, 10'h3FF, 10'h3FF, 8'h00, 8'h00, 8'h00, 1, 1, 0, 0};
    vecs[3]  = '{36,  0, 10'h3FF, 10'h3FF, 10'h3FF, 8'h00, 8'h00, 8'h00, 0, 1, 0, 0};
    vecs[4]  = '{43,  0, 10'h3FF, 10'h3FF, 10'h3FF, 8'h00, 8'h00, 8'h00, 0, 1, 0, 0};
    vecs[5]  = '{44,  0, 10'h3FF, 10'h3FF, 10'h3FF, 8'h00, 8'h00, 8'h00, 1, 1, 0, 0};
    vecs[6]  = '{47,  0, 10'h3FF, 10'h3FF, 10'h3FF, 8'h00, 8'h00, 8'h00, 1, 1, 0, 0};
    vecs[7]  = '{10,  1, 10'h1FF, 10'h003, 10'h2AA, 8'h7F, 8'h00, 8'hAA, 1, 1, 1, 0};
    vecs[8]  = '{ 0, 11, 10'h3FF, 10'h3FF, 10'h3FF, 8'hFF, 8'hFF, 8'hFF, 1, 1, 1, 0};
    vecs[9]  = '{31, 11, 10'h3FF, 10'h3FF, 10'h3FF, 8'hFF, 8'hFF, 8'hFF, 1, 1, 1, 0};
    vecs[10] = '{32, 12, 10'h3FF, 10'h3FF, 10'h3FF, 8'h00, 8'h00, 8'h00, 1, 1, 0, 0};
    vecs[11] = '{40, 13, 10'h3FF, 10'h3FF, 10'h3FF, 8'h00, 8'h00, 8'h00, 0, 1, 0, 0};
    vecs[12] = '{ 0, 14, 10'h3FF, 10'h3FF, 10'h3FF, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0};
    vecs[13] = '{40, 15, 10'h3FF, 10'h3FF, 10'h3FF, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0};
    vecs[14] = '{ 0, 16, 10'h3FF, 10'h3FF, 10'h3FF, 8'h00, 8'h00, 8'h00, 1, 1, 0, 0};
    vecs[15] = '{20, 17, 10'h3FF, 10'h3FF, 10'h3FF, 8'h00, 8'h00, 8'h00, 1, 1, 0, 0};
    vecs[16] = '{47, 18, 10'h3FF, 10'h3FF, 10'h3FF, 8'h00, 8'h00, 8'h00, 1, 1, 0, 0};
    vecs[17] = '{ 0,  0, 10'h3FF, 10'h3FF, 10'h3FF, 8'hFF, 8'hFF, 8'hFF, 1, 1, 1, 1};

    // Reset and start-up.
    set_rgb(10'h3FF, 10'h000, 10'h000);
    rst_n = 1'b0;
    repeat (5) step();
    check("rst_hs",      {31'd0, vif.o_vga_hs}, 32'd1);
    check("rst_vs",      {31'd0, vif.o_vga_vs}, 32'd1);
    check("rst_blank_n", {31'd0, vif.o_vga_blank_n}, 32'd0);
    check("rst_rgb",     {8'd0, vif.o_vga_r, vif.o_vga_g, vif.o_vga_b}, 32'd0);
    check("rst_fs",      {31'd0, vif.o_frame_start}, 32'd0);
    check("rst_sync_n",  {31'd0, vif.o_vga_sync_n}, 32'd0);
    rst_n = 1'b1;
    check("start_x", vif.o_x, 32'd0);
    check("start_y", vif.o_y, 32'd0);
    step();
`ifdef VGA_TESTBAR_EN
    er = 8'h00;
`else
    er = 8'hFF;
`endif
    check("start_fs",      {31'd0, vif.o_frame_start}, 32'd1);
    check("start_blank_n", {31'd0, vif.o_vga_blank_n}, 32'd1);
    check("start_r",       vif.o_vga_r, er);
    check("start_x1",      vif.o_x, 32'd1);
    step();
    check("start_fs_drop", {31'd0, vif.o_frame_start}, 32'd0);

    // Per-pixel vectors in raster order (the last one wraps into the next frame).
    for (int i = 0; i < NV; i++) begin
      goto(vecs[i].x, vecs[i].y);
      check($sformatf("v%0d_x", i), vif.o_x, vecs[i].x);
      check($sformatf("v%0d_y", i), vif.o_y, vecs[i].y);
      set_rgb(vecs[i].r, vecs[i].g, vecs[i].b);
      step();
      er = vecs[i].er; eg = vecs[i].eg; eb = vecs[i].eb;
`ifdef VGA_TESTBAR_EN
      if (vecs[i].ebl) {er, eg, eb} = bar(vecs[i].x);
`endif
      check($sformatf("v%0d_r", i),       vif.o_vga_r, er);
      check($sformatf("v%0d_g", i),       vif.o_vga_g, eg);
      check($sformatf("v%0d_b", i),       vif.o_vga_b, eb);
      check($sformatf("v%0d_hs", i),      {31'd0, vif.o_vga_hs}, {31'd0, vecs[i].ehs});
      check($sformatf("v%0d_vs", i),      {31'd0, vif.o_vga_vs}, {31'd0, vecs[i].evs});
      check($sformatf("v%0d_blank_n", i), {31'd0, vif.o_vga_blank_n}, {31'd0, vecs[i].ebl});
      check($sformatf("v%0d_fs", i),      {31'd0, vif.o_frame_start}, {31'd0, vecs[i].efs});
    end

    // Two full frames with full-scale color.
    set_rgb(10'h3FF, 10'h3FF, 10'h3FF);
    mon_en = 1'b1;
    n = 0;
    while (mon_cnt < 2 * FRAME && n < 2 * FRAME + 10) begin
      step();
      n++;
    end
    mon_en = 1'b0;
    check("mon_samples",    mon_cnt, 2 * FRAME);
    check("hs_low_total",   hs_low, 2 * V_TOTAL * H_SYNC);
    check("vs_low_total",   vs_low, 2 * V_SYNC * H_TOTAL);
    check("active_total",   act_cnt, 2 * H_ACTIVE * V_ACTIVE);
    check("corner_seen",    corner_cnt, 2);
    check("coord_errors",   coord_err, 0);
    check("blank_rgb_errs", blank_err, 0);
    check("active_rgb_errs", color_err, 0);
    check("sync_n_errors",  sync_err, 0);
    check("blank_pos_errs", blank_pos_err, 0);
    check("hs_fall_pos",    hs_fall_err, 0);
    check("vs_fall_pos",    vs_fall_err, 0);
    check("fs_count",       fs_cnt, 2);
    check("fs_position",    fs_pos_err, 0);
    check("fs_period",      fs_period, FRAME);

    // Mid-frame asynchronous reset.
    goto(20, 5);
    check("mid_pre_blank_n", {31'd0, vif.o_vga_blank_n}, 32'd1);
    #5 rst_n = 1'b0;
    #1;
    check("mid_x",       vif.o_x, 32'd0);
    check("mid_y",       vif.o_y, 32'd0);
    check("mid_hs",      {31'd0, vif.o_vga_hs}, 32'd1);
    check("mid_vs",      {31'd0, vif.o_vga_vs}, 32'd1);
    check("mid_blank_n", {31'd0, vif.o_vga_blank_n}, 32'd0);
    check("mid_rgb",     {8'd0, vif.o_vga_r, vif.o_vga_g, vif.o_vga_b}, 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    check("mid_rel_x", vif.o_x, 32'd0);
    step();
`ifdef VGA_TESTBAR_EN
    er = 8'h00;
`else
    er = 8'hFF;
`endif
    check("mid_rel_fs",      {31'd0, vif.o_frame_start}, 32'd1);
    check("mid_rel_blank_n", {31'd0, vif.o_vga_blank_n}, 32'd1);
    check("mid_rel_r",       vif.o_vga_r, er);
    check("mid_rel_x1",      vif.o_x, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
